// File: rtl/term_fifo_bank_pkg.sv
// term_pkg: shared constants for the terminal FIFO bank.
//   ID_W / ID_MSB_OFS : packet ID field, ID_W bits starting ID_MSB_OFS below the MSB
//   BCNT_W            : width of the per-channel broadcast counter
//   CNT_W(depth)      : width of an occupancy count able to hold 0..depth
package term_pkg;

    localparam int ID_W       = 8;
    localparam int ID_MSB_OFS = 0;
    localparam int BCNT_W     = 16;

    function automatic int CNT_W(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/term_fifo_bank_if.sv
// term_fifo_bank_if: per-channel host/mesh signals of the FIFO bank.
//   push, data_in      host write strobe and packet per channel
//   full               channel holds fifo_depth entries
//   pop                mesh read strobe per channel
//   pndng, data_out    channel non-empty and its head packet (FWFT)
//   count              occupancy per channel
//   overflow           sticky dropped-push flag per channel
//   bdcst_cnt          saturating count of accepted broadcast packets
// master = host/mesh side driving strobes, slave = the FIFO bank.
interface term_fifo_bank_if
    import term_pkg::*;
#(
    parameter int NUM_TERM   = 16,
    parameter int pckg_sz    = 41,
    parameter int fifo_depth = 8
);
    localparam int CW = CNT_W(fifo_depth);

    logic [NUM_TERM-1:0]               push;
    logic [NUM_TERM-1:0][pckg_sz-1:0]  data_in;
    logic [NUM_TERM-1:0]               full;
    logic [NUM_TERM-1:0]               pop;
    logic [NUM_TERM-1:0]               pndng;
    logic [NUM_TERM-1:0][pckg_sz-1:0]  data_out;
    logic [NUM_TERM-1:0][CW-1:0]       count;
    logic [NUM_TERM-1:0]               overflow;
    logic [NUM_TERM-1:0][BCNT_W-1:0]   bdcst_cnt;

    modport master (
        output push, data_in, pop,
        input  full, pndng, data_out, count, overflow, bdcst_cnt
    );

    modport slave (
        input  push, data_in, pop,
        output full, pndng, data_out, count, overflow, bdcst_cnt
    );

endinterface

// File: rtl/term_fifo_bank_fifo.sv
// term_fifo: one first-word-fall-through packet channel.
//   clk, reset   clock / async active-high reset of control state
//   clr_ovf      synchronous clear of the overflow flag (a same-cycle drop wins)
//   push/data_in host write; accepted unless full without a same-cycle pop
//   pop          mesh read; ignored when empty
//   full, pndng, count, data_out   decodes of registered state only
//   overflow     sticky, set on a dropped push
//   bdcst_cnt    saturating count of accepted broadcast packets
module term_fifo
    import term_pkg::*;
#(
    parameter int              pckg_sz    = 41,
    parameter int              fifo_depth = 8,
    parameter logic [ID_W-1:0] bdcst      = 8'hFF,
    localparam int             CW         = CNT_W(fifo_depth)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_ovf,
    input  logic               push,
    input  logic [pckg_sz-1:0] data_in,
    input  logic               pop,
    output logic               full,
    output logic               pndng,
    output logic [pckg_sz-1:0] data_out,
    output logic [CW-1:0]      count,
    output logic               overflow,
    output logic [BCNT_W-1:0]  bdcst_cnt
);
    localparam int          PW      = $clog2(fifo_depth);
    localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth);

    logic [pckg_sz-1:0] mem [fifo_depth];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;
    logic               drop;
    logic               is_bdcst;

    // A pop on a full channel frees the slot the same cycle, so the push goes in.
    always_comb begin
        do_pop   = pop && (count != '0);
        do_push  = push && ((count != DEPTH_C) || pop);
        drop     = push && !do_push;
        is_bdcst = (data_in[pckg_sz-1-ID_MSB_OFS -: ID_W] == bdcst);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            bdcst_cnt <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
            if (do_push && is_bdcst && (bdcst_cnt != '1))
                bdcst_cnt <= bdcst_cnt + 1'b1;
        end
    end

    // Storage carries no reset; data_out is masked while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    always_comb begin
        full     = (count == DEPTH_C);
        pndng    = (count != '0);
        data_out = pndng ? mem[rd_ptr] : '0;
    end

endmodule

// File: rtl/term_fifo_bank.sv
// term_fifo_bank: NUM_TERM independent FWFT packet FIFOs between host and mesh.
//   clk, reset   clock / async active-high reset
//   clr_ovf      clears every channel's overflow flag
//   bus          per-channel push/data_in/full and pop/pndng/data_out handshakes
//                plus count, overflow and bdcst_cnt status
module term_fifo_bank
    import term_pkg::*;
#(
    parameter int              NUM_TERM   = 16,
    parameter int              pckg_sz    = 41,
    parameter int              fifo_depth = 8,
    parameter logic [ID_W-1:0] bdcst      = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_ovf,
    term_fifo_bank_if.slave   bus
);

    for (genvar i = 0; i < NUM_TERM; i++) begin : g_ch
        term_fifo #(
            .pckg_sz    (pckg_sz),
            .fifo_depth (fifo_depth),
            .bdcst      (bdcst)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .clr_ovf   (clr_ovf),
            .push      (bus.push[i]),
            .data_in   (bus.data_in[i]),
            .pop       (bus.pop[i]),
            .full      (bus.full[i]),
            .pndng     (bus.pndng[i]),
            .data_out  (bus.data_out[i]),
            .count     (bus.count[i]),
            .overflow  (bus.overflow[i]),
            .bdcst_cnt (bus.bdcst_cnt[i])
        );
    end

endmodule

// File: tb/tb_term_fifo_bank.sv
// Bench for term_fifo_bank: directed steps plus random traffic, every output
// compared against a queue-per-channel reference model.
module tb_term_fifo_bank;
    import term_pkg::*;

    localparam int NT = 16;
    localparam int PW = 41;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic reset;
    logic clr_ovf;
    int   total  = 0;
    int   passed = 0;
    bit   chk_en = 1'b1;

    always #5 clk = ~clk;

    term_fifo_bank_if #(.NUM_TERM(NT), .pckg_sz(PW), .fifo_depth(D)) bus ();

    term_fifo_bank #(
        .NUM_TERM   (NT),
        .pckg_sz    (PW),
        .fifo_depth (D),
        .bdcst      (8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clr_ovf (clr_ovf),
        .bus     (bus)
    );

    // Reference model
    logic [PW-1:0] q [NT][$];
    bit            ovf_m [NT];
    int unsigned   bcnt_m [NT];

    task automatic model_reset();
        for (int c = 0; c < NT; c++) begin
            q[c].delete();
            ovf_m[c]  = 1'b0;
            bcnt_m[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NT; c++) begin
            int  n;
            bit  acc;
            n   = q[c].size();
            acc = bus.push[c] && (n < D || bus.pop[c]);
            if (bus.pop[c] && n > 0) void'(q[c].pop_front());
            if (acc) begin
                q[c].push_back(bus.data_in[c]);
                if (bus.data_in[c][PW-1 -: 8] == 8'hFF && bcnt_m[c] < 65535)
                    bcnt_m[c]++;
            end
            if (bus.push[c] && !acc) ovf_m[c] = 1'b1;
            else if (clr_ovf)        ovf_m[c] = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input int ch, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s ch%0d: got %0h expected %0h", tag, ch, got, exp);
    endtask

    task automatic check_all();
        for (int c = 0; c < NT; c++) begin
            int n;
            n = q[c].size();
            chk("count",     c, 64'(bus.count[c]),     64'(n));
            chk("pndng",     c, 64'(bus.pndng[c]),     64'(n > 0));
            chk("full",      c, 64'(bus.full[c]),      64'(n == D));
            chk("data_out",  c, 64'(bus.data_out[c]),  (n > 0) ? 64'(q[c][0]) : 64'd0);
            chk("overflow",  c, 64'(bus.overflow[c]),  64'(ovf_m[c]));
            chk("bdcst_cnt", c, 64'(bus.bdcst_cnt[c]), 64'(bcnt_m[c]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (chk_en) check_all();
    endtask

    task automatic idle();
        bus.push = '0;
        bus.pop  = '0;
        clr_ovf  = 1'b0;
    endtask

    function automatic logic [PW-1:0] mk(input logic [7:0] id);
        return {id, $urandom(), 1'($urandom())};
    endfunction

    function automatic logic [7:0] rnd_id();
        return ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom());
    endfunction

    initial begin
        reset       = 1'b1;
        bus.data_in = '0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all();

        // ch3: fill, overflow, drain in order
        for (int i = 0; i < 8; i++) begin
            bus.push[3]    = 1'b1;
            bus.data_in[3] = mk(8'h10 + 8'(i));
            tick();
        end
        idle();
        chk("fill_full", 3, 64'(bus.full[3]), 64'd1);
        chk("fill_cnt",  3, 64'(bus.count[3]), 64'd8);
        bus.push[3]    = 1'b1;
        bus.data_in[3] = mk(8'h55);
        tick();
        idle();
        chk("ovf9",     3, 64'(bus.overflow[3]), 64'd1);
        chk("ovf9_cnt", 3, 64'(bus.count[3]), 64'd8);
        bus.pop[3] = 1'b1;
        repeat (8) tick();
        idle();
        chk("drained", 3, 64'(bus.pndng[3]), 64'd0);

        // ch3: clear, refill, push+pop while full
        clr_ovf = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 8; i++) begin
            bus.push[3]    = 1'b1;
            bus.data_in[3] = mk(8'h20);
            tick();
        end
        bus.pop[3]     = 1'b1;
        bus.data_in[3] = mk(8'h77);
        tick();
        idle();
        chk("fullpp_ovf", 3, 64'(bus.overflow[3]), 64'd0);
        chk("fullpp_cnt", 3, 64'(bus.count[3]), 64'd8);
        bus.pop[3] = 1'b1;
        repeat (8) tick();
        idle();

        // ch4: push+pop on empty
        bus.push[4]    = 1'b1;
        bus.pop[4]     = 1'b1;
        bus.data_in[4] = 41'h1_2345_6789;
        tick();
        idle();
        chk("epp_pndng", 4, 64'(bus.pndng[4]), 64'd1);
        chk("epp_cnt",   4, 64'(bus.count[4]), 64'd1);
        chk("epp_data",  4, 64'(bus.data_out[4]), 64'h1_2345_6789);

        // ch0: 3 broadcast, 2 ordinary
        for (int i = 0; i < 5; i++) begin
            bus.push[0]    = 1'b1;
            bus.data_in[0] = mk((i < 3) ? 8'hFF : 8'h21);
            tick();
        end
        idle();
        chk("bcnt3", 0, 64'(bus.bdcst_cnt[0]), 64'd3);

        // ch5: overflow, clear alone, clear with drop
        for (int i = 0; i < 9; i++) begin
            bus.push[5]    = 1'b1;
            bus.data_in[5] = mk(8'h05);
            tick();
        end
        idle();
        chk("ovf5_set", 5, 64'(bus.overflow[5]), 64'd1);
        clr_ovf = 1'b1;
        tick();
        idle();
        chk("ovf5_clr", 5, 64'(bus.overflow[5]), 64'd0);
        clr_ovf        = 1'b1;
        bus.push[5]    = 1'b1;
        bus.data_in[5] = mk(8'h06);
        tick();
        idle();
        chk("ovf5_setwins", 5, 64'(bus.overflow[5]), 64'd1);

        // ch1: 5 entries then asynchronous reset between edges
        for (int i = 0; i < 5; i++) begin
            bus.push[1]    = 1'b1;
            bus.data_in[1] = mk(8'h01);
            tick();
        end
        idle();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("areset_cnt1", 1, 64'(bus.count[1]), 64'd0);
        #1;
        reset          = 1'b0;
        bus.push[1]    = 1'b1;
        bus.data_in[1] = 41'h0AB_CDEF_0123;
        tick();
        idle();
        chk("post_reset_data", 1, 64'(bus.data_out[1]), 64'h0AB_CDEF_0123);

        // random traffic: push-heavy then pop-heavy
        for (int i = 0; i < 2000; i++) begin
            if (i < 1000) begin
                bus.push = 16'($urandom() | $urandom());
                bus.pop  = 16'($urandom() & $urandom());
            end else begin
                bus.push = 16'($urandom() & $urandom());
                bus.pop  = 16'($urandom() | $urandom());
            end
            for (int c = 0; c < NT; c++) bus.data_in[c] = mk(rnd_id());
            clr_ovf = ($urandom_range(15) == 0);
            tick();
        end
        idle();
        tick();

        // ch2: stream broadcasts through until the counter saturates
        chk_en      = 1'b0;
        bus.push[2] = 1'b1;
        bus.pop[2]  = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            bus.data_in[2] = mk(8'hFF);
            tick();
            if (i % 8192 == 0) check_all();
        end
        idle();
        chk_en = 1'b1;
        tick();
        chk("bcnt_sat", 2, 64'(bus.bdcst_cnt[2]), 64'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
